counter_10: RTL and testbench



---
 rtl/counter_10_if.sv | 21 ++
 rtl/counter_10.sv | 63 ++++++
 tb/tb_counter_10.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_10_if.sv
// Count-digit bus: enable in, count value and ripple carry out.
// The master side drives EN; the counter stage (slave) drives Q and CO.
interface counter_10_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic [WIDTH-1:0] Q;
    logic             CO;

    modport master (
        output EN,
        input  Q,
        input  CO
    );

    modport slave (
        input  EN,
        output Q,
        output CO
    );
endinterface

// File: rtl/counter_10.sv
// Synchronous mod-MODULUS up-counter digit with enable, synchronous clear (nCR)
// and a combinational ripple carry, intended to be cascaded CO -> EN into BCD chains.
module counter_10 #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic          CP,
    input  logic          nCR,
    counter_10_if.slave   bus
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_COUNT = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_COUNT  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Values at or above the last count (only reachable by upset) also wrap to zero.
    function automatic logic wrapsNext(input logic [WIDTH-1:0] value);
        return (value >= LAST_COUNT);
    endfunction

    function automatic logic isLast(input logic [WIDTH-1:0] value);
        return (value == LAST_COUNT);
    endfunction

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] nextCount_s;
    logic             carry_s;

    // Next-state selection: clear beats enable, enable beats hold.
    always_comb begin
        nextCount_s = count_r;
        if (nCR) begin
            nextCount_s = ZERO_COUNT;
        end else if (bus.EN) begin
            if (wrapsNext(count_r)) begin
                nextCount_s = ZERO_COUNT;
            end else begin
                nextCount_s = count_r + ONE_COUNT;
            end
        end else begin
            nextCount_s = count_r;
        end
    end

    // Count register; the only state in the block.
    always_ff @(posedge CP) begin
        count_r <= nextCount_s;
    end

    // Carry must follow EN within the same cycle so the next digit sees it before the edge.
    always_comb begin
        carry_s = 1'b0;
        if (!nCR && bus.EN && isLast(count_r)) begin
            carry_s = 1'b1;
        end else begin
            carry_s = 1'b0;
        end
    end

    assign bus.Q  = count_r;
    assign bus.CO = carry_s;

endmodule

// File: tb/tb_counter_10.sv
// Directed bench for counter_10: clear, count/wrap, hold, clear priority,
// two-digit cascade and recovery from an out-of-range count.
module tb_counter_10;

    logic CP;
    logic nCR;
    logic nCRc;
    int   errors;
    int   checks;

    counter_10_if #(.WIDTH(4)) busA ();
    counter_10_if #(.WIDTH(4)) busOnes ();
    counter_10_if #(.WIDTH(4)) busTens ();

    counter_10 #(.WIDTH(4), .MODULUS(10)) dut (
        .CP  (CP),
        .nCR (nCR),
        .bus (busA.slave)
    );

    counter_10 #(.WIDTH(4), .MODULUS(10)) onesDigit (
        .CP  (CP),
        .nCR (nCRc),
        .bus (busOnes.slave)
    );

    counter_10 #(.WIDTH(4), .MODULUS(10)) tensDigit (
        .CP  (CP),
        .nCR (nCRc),
        .bus (busTens.slave)
    );

    assign busTens.EN = busOnes.CO;

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        nCR = 1'b1;
        busA.EN = 1'b1;
        step();
        checks++;
        if (busA.Q !== 4'd0) begin
            errors++;
            $display("FAIL reset_q got=%0d exp=0", busA.Q);
        end
        checks++;
        if (busA.CO !== 1'b0) begin
            errors++;
            $display("FAIL reset_co got=%b exp=0", busA.CO);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busA.Q !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold%0d got=%0d exp=0", i, busA.Q);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [3:0] expQ;
        nCR = 1'b0;
        busA.EN = 1'b1;
        #1;
        checks++;
        if (busA.CO !== 1'b0) begin
            errors++;
            $display("FAIL wrap_co_start got=%b exp=0", busA.CO);
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            expQ = 4'(i % 10);
            checks++;
            if (busA.Q !== expQ) begin
                errors++;
                $display("FAIL wrap_q%0d got=%0d exp=%0d", i, busA.Q, expQ);
            end
            checks++;
            if (busA.CO !== (expQ == 4'd9)) begin
                errors++;
                $display("FAIL wrap_co%0d got=%b exp=%b", i, busA.CO, (expQ == 4'd9));
            end
        end
    endtask

    task automatic test_hold();
        nCR = 1'b1;
        step();
        nCR = 1'b0;
        busA.EN = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (busA.Q !== 4'd5) begin
            errors++;
            $display("FAIL hold_reach5 got=%0d exp=5", busA.Q);
        end
        busA.EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (busA.Q !== 4'd5) begin
                errors++;
                $display("FAIL hold_q%0d got=%0d exp=5", i, busA.Q);
            end
            checks++;
            if (busA.CO !== 1'b0) begin
                errors++;
                $display("FAIL hold_co%0d got=%b exp=0", i, busA.CO);
            end
        end
        busA.EN = 1'b1;
        step();
        checks++;
        if (busA.Q !== 4'd6) begin
            errors++;
            $display("FAIL hold_resume got=%0d exp=6", busA.Q);
        end
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (busA.Q !== 4'd9 || busA.CO !== 1'b1) begin
            errors++;
            $display("FAIL prio_at9 got q=%0d co=%b exp q=9 co=1", busA.Q, busA.CO);
        end
        nCR = 1'b1;
        #1;
        checks++;
        if (busA.CO !== 1'b0) begin
            errors++;
            $display("FAIL prio_co_during_clear got=%b exp=0", busA.CO);
        end
        step();
        checks++;
        if (busA.Q !== 4'd0 || busA.CO !== 1'b0) begin
            errors++;
            $display("FAIL prio_cleared got q=%0d co=%b exp q=0 co=0", busA.Q, busA.CO);
        end
        nCR = 1'b0;
        step();
        checks++;
        if (busA.Q !== 4'd1) begin
            errors++;
            $display("FAIL prio_resume got=%0d exp=1", busA.Q);
        end
    endtask

    task automatic test_cascade();
        nCRc = 1'b1;
        busOnes.EN = 1'b1;
        step();
        nCRc = 1'b0;
        for (int i = 0; i < 37; i++) step();
        checks++;
        if (busTens.Q !== 4'd3 || busOnes.Q !== 4'd7) begin
            errors++;
            $display("FAIL cascade37 got tens=%0d ones=%0d exp tens=3 ones=7", busTens.Q, busOnes.Q);
        end
        for (int i = 0; i < 63; i++) step();
        checks++;
        if (busTens.Q !== 4'd0 || busOnes.Q !== 4'd0) begin
            errors++;
            $display("FAIL cascade100 got tens=%0d ones=%0d exp tens=0 ones=0", busTens.Q, busOnes.Q);
        end
    endtask

    task automatic test_illegal();
        nCR = 1'b0;
        busA.EN = 1'b1;
        force dut.count_r = 4'd12;
        #1;
        checks++;
        if (busA.Q !== 4'd12 || busA.CO !== 1'b0) begin
            errors++;
            $display("FAIL illegal_forced got q=%0d co=%b exp q=12 co=0", busA.Q, busA.CO);
        end
        @(negedge CP);
        release dut.count_r;
        step();
        checks++;
        if (busA.Q !== 4'd0) begin
            errors++;
            $display("FAIL illegal_recover got=%0d exp=0", busA.Q);
        end
        step();
        checks++;
        if (busA.Q !== 4'd1) begin
            errors++;
            $display("FAIL illegal_resume got=%0d exp=1", busA.Q);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nCR = 1'b1;
        nCRc = 1'b1;
        busA.EN = 1'b0;
        busOnes.EN = 1'b0;
        test_reset();
        test_count_wrap();
        test_hold();
        test_clear_priority();
        test_cascade();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
